// File: rtl/sprite_mover_plotter.sv
// Purpose : player-sprite engine; keeps the sprite origin, applies a clamped
//           left/right move, erases the old image and redraws from a sprite ROM.
// Latency : draw-only update done N+1 cycles after start, 2N+2 with erase; one pixel per clock.
// Backpressure: none downstream (VGA write port always accepts); start is ignored while busy.
//
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   start                  request one update (sampled only in IDLE)
//   move_req, move_dir     move this update; 0 = left, 1 = right (sampled with start)
//   rom_addr / rom_data    sprite ROM, row-major address, data 1 cycle after address
//   x_out, y_out,
//   colour_out, plot_out   VGA write port
//   x_pos                  current sprite origin x
//   busy, done             busy outside IDLE; done pulses for one cycle at the end
module sprite_mover_plotter #(
    parameter int         SPR_W     = 28,
    parameter int         SPR_H     = 20,
    parameter int         X_W       = 9,
    parameter int         Y_W       = 8,
    parameter int         A_W       = 10,
    parameter int         STEP      = 1,
    parameter int         X_MIN     = 0,
    parameter int         X_MAX     = 292,
    parameter int         X_INIT    = 146,
    parameter int         Y_POS     = 200,
    parameter logic [2:0] BG_COLOUR = 3'b000,
    parameter int         ERASE_EN  = 1
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           start,
    input  logic           move_req,
    input  logic           move_dir,
    output logic [A_W-1:0] rom_addr,
    input  logic [2:0]     rom_data,
    output logic [X_W-1:0] x_out,
    output logic [Y_W-1:0] y_out,
    output logic [2:0]     colour_out,
    output logic           plot_out,
    output logic [X_W-1:0] x_pos,
    output logic           busy,
    output logic           done
);

    localparam int N  = SPR_W * SPR_H;
    localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

    localparam logic [A_W-1:0] LAST_ADDR = A_W'(N - 1);
    localparam logic [CW-1:0]  LAST_COL  = CW'(SPR_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_MOVE,
        S_DRAW,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [X_W-1:0]  x_pos_q, x_pos_d;
    logic [X_W-1:0]  x_next_q, x_next_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic [A_W-1:0]  addr_q, addr_d;

    // Pixel pipeline stage: one cycle behind the counters so it lines up with rom_data.
    logic            plot_q;
    logic            erase_pix_q;
    logic [X_W-1:0]  x_out_q;
    logic [Y_W-1:0]  y_out_q;

    // Clamped candidate position. Left move compares before subtracting so a
    // position near X_MIN never wraps to the top of the coordinate range.
    logic [X_W:0]    x_ext;
    logic [X_W:0]    right_sum;
    logic [X_W-1:0]  x_right;
    logic [X_W-1:0]  x_left;
    logic [X_W-1:0]  x_cand;
    logic            moving;
    logic            in_pass;
    logic            last_pix;

    always_comb begin
        x_ext     = {1'b0, x_pos_q};
        right_sum = x_ext + (X_W+1)'(STEP);
        x_right   = (right_sum > (X_W+1)'(X_MAX)) ? X_W'(X_MAX) : right_sum[X_W-1:0];
        x_left    = (x_ext >= (X_W+1)'(X_MIN + STEP)) ? (x_pos_q - X_W'(STEP)) : X_W'(X_MIN);
        x_cand    = move_dir ? x_right : x_left;
        // A clamped move that lands on the current position is treated as no move.
        moving    = move_req && (x_cand != x_pos_q);
    end

    assign in_pass  = (state_q == S_ERASE) || (state_q == S_DRAW);
    assign last_pix = (addr_q == LAST_ADDR);

    // Next-state and counter logic
    always_comb begin
        state_d  = state_q;
        x_pos_d  = x_pos_q;
        x_next_d = x_next_q;
        col_d    = col_q;
        row_d    = row_q;
        addr_d   = addr_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_next_d = x_cand;
                    if (moving && (ERASE_EN != 0)) begin
                        state_d = S_ERASE;
                    end else if (moving) begin
                        state_d = S_MOVE;
                    end else begin
                        state_d = S_DRAW;
                    end
                end
            end

            S_ERASE, S_DRAW: begin
                if (last_pix) begin
                    col_d   = '0;
                    row_d   = '0;
                    addr_d  = '0;
                    state_d = (state_q == S_ERASE) ? S_MOVE : S_DONE;
                end else begin
                    addr_d = addr_q + 1'b1;
                    if (col_q == LAST_COL) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end

            S_MOVE: begin
                x_pos_d = x_next_q;
                state_d = S_DRAW;
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            x_pos_q  <= X_W'(X_INIT);
            x_next_q <= X_W'(X_INIT);
            col_q    <= '0;
            row_q    <= '0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            x_pos_q  <= x_pos_d;
            x_next_q <= x_next_d;
            col_q    <= col_d;
            row_q    <= row_d;
            addr_q   <= addr_d;
        end
    end

    // Coordinates are captured in the address cycle using the x_pos of that
    // cycle, so the final erase pixel (plotted during MOVE) still uses the old origin.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            plot_q      <= 1'b0;
            erase_pix_q <= 1'b0;
            x_out_q     <= '0;
            y_out_q     <= '0;
        end else begin
            plot_q      <= in_pass;
            erase_pix_q <= (state_q == S_ERASE);
            x_out_q     <= in_pass ? (x_pos_q + X_W'(col_q)) : '0;
            y_out_q     <= in_pass ? (Y_W'(Y_POS) + Y_W'(row_q)) : '0;
        end
    end

    assign rom_addr   = addr_q;
    assign x_out      = x_out_q;
    assign y_out      = y_out_q;
    assign plot_out   = plot_q;
    // rom_data arrives one cycle after rom_addr, i.e. in the plot cycle itself.
    assign colour_out = plot_q ? (erase_pix_q ? BG_COLOUR : rom_data) : 3'b000;
    assign x_pos      = x_pos_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);

endmodule

// File: doc/sprite_mover_plotter.md
Name: sprite_mover_plotter

Overview:
- Parametrised player-sprite engine for the 320x240 VGA path.
- Holds the sprite's horizontal position and applies a clamped left/right move on request.
- On a move, erases the old image with the background colour, then redraws the sprite from an external sprite ROM, one pixel per clock.
- Sits between the game controller (start/done handshake) and the VGA adapter write port, and replaces the fixed-size single-step player plotter.

Parameters:
- SPR_W, 28, sprite width in pixels.
- SPR_H, 20, sprite height in pixels.
- X_W, 9, x coordinate width.
- Y_W, 8, y coordinate width.
- A_W, 10, ROM address width; must satisfy 2^A_W >= SPR_W*SPR_H.
- STEP, 1, pixels moved per accepted move request.
- X_MIN, 0, leftmost allowed sprite origin.
- X_MAX, 292, rightmost allowed sprite origin (320 - SPR_W).
- X_INIT, 146, origin x after reset.
- Y_POS, 200, fixed origin y.
- BG_COLOUR, 3'b000, colour written during erase.
- ERASE_EN, 1, 1 = erase the old image before moving; 0 = no erase pass.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous, active-low reset.
- start  in  1  request one update cycle; sampled only in IDLE.
- move_req  in  1  move during this update; sampled with start.
- move_dir  in  1  0 = left, 1 = right; sampled with start.
- rom_addr  out  A_W  sprite ROM address, row-major: row*SPR_W + col.
- rom_data  in  3  ROM colour; valid exactly 1 cycle after rom_addr.
- x_out  out  X_W  pixel x to VGA.
- y_out  out  Y_W  pixel y to VGA.
- colour_out  out  3  pixel colour to VGA.
- plot_out  out  1  VGA write enable.
- x_pos  out  X_W  current sprite origin x.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of update.

Behaviour:
- N = SPR_W*SPR_H pixels per pass; col counts 0..SPR_W-1, row counts 0..SPR_H-1; addr counts 0..N-1 (A_W bits).
- Reset (synchronous, any state including mid-pass):
  - state = IDLE, x_pos = X_INIT, counters = 0.
  - plot_out, done, busy = 0; x_out/y_out/colour_out = 0; rom_addr = 0.
- States: IDLE, ERASE, MOVE, DRAW, DONE.
- IDLE, start = 1: latch move_req/move_dir; compute x_next.
  - Right: x_next = min(x_pos+STEP, X_MAX). Left: x_next = max(x_pos-STEP, X_MIN).
  - Compute the left move without unsigned wrap (compare before subtract).
  - Go to ERASE if move_req && x_next != x_pos && ERASE_EN.
  - Else go to MOVE if move_req && x_next != x_pos.
  - Else go to DRAW. A move that clamps to the same position is a no-op: no erase, draw only.
- ERASE and DRAW each last exactly N cycles; the pixel counter steps once per cycle, then clears on exit.
- ERASE next state: MOVE. DRAW next state: DONE.
- MOVE: 1 cycle; x_pos <= x_next; next state DRAW.
- DONE: 1 cycle; done = 1; next state IDLE.
- Pixel pipeline (identical for both passes):
  - In a pass cycle, rom_addr = addr.
  - Next cycle: plot_out = 1, x_out = x_pos + col, y_out = Y_POS + row (col/row delayed 1 cycle).
  - colour_out = rom_data (DRAW) or BG_COLOUR (ERASE).
  - The last pixel of a pass is plotted in the first cycle of the following state (MOVE or DONE).
  - ERASE plots use the pre-move x_pos.
- plot_out is low at all other times.
- No transparency: every pixel, including colour 0, is written.
- start while busy is ignored (no queueing). move_req/move_dir changing mid-update has no effect.
- Latency:
  - Draw only: start at cycle 0 → first plot at cycle 2, done at cycle N+1, IDLE at N+2.
  - With erase: done at cycle 2N+2.

Test Plan:
- Reset → all outputs 0 except x_pos = 146; busy = 0.
- start, move_req = 0 (N = 560) → exactly 560 plot_out pulses.
  - First pixel (146,200), colour ROM[0]; last pixel (173,219), colour ROM[559].
  - done high on the cycle of the last plot; busy drops on the next cycle.
- start, move_req = 1, dir = 1 → 560 plots of colour 000 at origin x = 146, then x_pos = 147.
  - Then 560 ROM plots at origin 147; done at cycle 1122.
- x_pos = 292, move right (and x_pos = 0, move left) → no erase plots, x_pos unchanged, 560 draw plots only; no wrap to 511.
- Pulse start again 10 cycles into DRAW → ignored; exactly one done and 560 plots.
- Assert resetn = 0 at pixel 300 of DRAW → next cycle IDLE, plot_out = 0, x_pos = 146.
  - A following start produces a full 560-pixel pass from address 0.
